chop_phase_demod: RTL and testbench

Digital controller for the chopped bandgap. It generates the non-overlapping two-phase chopper clocks `phi1`/`phi2` that drive the bandgap's chopper switches. It also consumes the comparator output that follows the bandgap and demodulates it synchronously against the chop phase, producing a signed 8-bit offset/trim measurement per request.

---
 rtl/chop_pkg.sv | 25 ++
 rtl/chop_phase_gen.sv | 68 ++++++
 rtl/chop_phase_demod.sv | 110 +++++++++++
 tb/tb_chop_phase_demod.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/chop_pkg.sv
// Shared types and helpers for the chopped-bandgap phase controller.
package chop_pkg;

    localparam int DIV_W = 10;  // wide enough for H-1 up to 511
    localparam int ACC_W = 8;   // |acc| <= 126 always fits

    typedef enum logic { PH_A = 1'b0, PH_B = 1'b1 } phase_e;

    typedef enum logic [1:0] { IDLE, ARM, RUN, DONE } fsm_e;

    // Half-period length in clk cycles: 4 << div.
    function automatic logic [DIV_W-1:0] half_len(input logic [2:0] div);
        return DIV_W'(4) << div;
    endfunction

    // Dead time: dead+1, clamped to H-1 so each phase is high at least one cycle.
    function automatic logic [DIV_W-1:0] dead_len(input logic [2:0] div, input logic [1:0] dead);
        logic [DIV_W-1:0] d;
        logic [DIV_W-1:0] hm1;
        d   = DIV_W'(dead) + DIV_W'(1);
        hm1 = half_len(div) - DIV_W'(1);
        return (d > hm1) ? hm1 : d;
    endfunction

endpackage

// File: rtl/chop_phase_gen.sv
// Non-overlapping two-phase chopper clock generator with boundary-latched settings.
module chop_phase_gen
    import chop_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena_i,
    input  logic [2:0] div_sel_i,
    input  logic [1:0] dead_sel_i,
    output logic       phi1_o,
    output logic       phi2_o,
    output logic       chop_state_o,
    output logic       half_start_o,
    output logic       sample_en_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    phase_e           ph_q, ph_d;
    logic [2:0]       div_q, div_d;
    logic [1:0]       dead_q, dead_d;
    logic             phi1_q, phi2_q;
    logic             last;

    assign last = (cnt_q == half_len(div_q) - DIV_W'(1));

    // Next counter/phase; settings only move at the end of a half-period.
    always_comb begin
        cnt_d  = cnt_q + DIV_W'(1);
        ph_d   = ph_q;
        div_d  = div_q;
        dead_d = dead_q;
        if (!ena_i) begin
            cnt_d = '0;
            ph_d  = PH_A;
        end else if (last) begin
            cnt_d  = '0;
            ph_d   = (ph_q == PH_A) ? PH_B : PH_A;
            div_d  = div_sel_i;
            dead_d = dead_sel_i;
        end
    end

    // Phase outputs are decoded from next state so the flops line up with cnt_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            ph_q   <= PH_A;
            div_q  <= '0;
            dead_q <= '0;
            phi1_q <= 1'b0;
            phi2_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            ph_q   <= ph_d;
            div_q  <= div_d;
            dead_q <= dead_d;
            phi1_q <= ena_i && (ph_d == PH_A) && (cnt_d >= dead_len(div_d, dead_d));
            phi2_q <= ena_i && (ph_d == PH_B) && (cnt_d >= dead_len(div_d, dead_d));
        end
    end

    assign phi1_o       = phi1_q;
    assign phi2_o       = phi2_q;
    assign chop_state_o = ph_q;
    assign half_start_o = (ph_q == PH_A) && (cnt_q == '0);
    assign sample_en_o  = last;

endmodule

// File: rtl/chop_phase_demod.sv
// Chopper controller top: phase generator plus synchronous demodulation of the comparator.
module chop_phase_demod
    import chop_pkg::*;
#(
    parameter int NPER = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [2:0]       div_sel,
    input  logic [1:0]       dead_sel,
    input  logic             start,
    input  logic             cmp_in,
    output logic             phi1,
    output logic             phi2,
    output logic             chop_state,
    output logic             busy,
    output logic [ACC_W-1:0] result,
    output logic             result_valid
);

    localparam logic [6:0]             LAST_SMP = 7'(2 * NPER - 1);
    localparam logic signed [ACC_W-1:0] ONE     = ACC_W'(1);

    logic half_start, sample_en;
    logic cmp_m_q, cmp_s_q;

    fsm_e                    st_q, st_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, acc_nxt;
    logic [6:0]              smp_q, smp_d;
    logic [ACC_W-1:0]        res_q, res_d;

    chop_phase_gen u_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena_i        (ena),
        .div_sel_i    (div_sel),
        .dead_sel_i   (dead_sel),
        .phi1_o       (phi1),
        .phi2_o       (phi2),
        .chop_state_o (chop_state),
        .half_start_o (half_start),
        .sample_en_o  (sample_en)
    );

    // Two-flop synchronizer for the asynchronous comparator output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_m_q <= 1'b0;
            cmp_s_q <= 1'b0;
        end else begin
            cmp_m_q <= cmp_in;
            cmp_s_q <= cmp_m_q;
        end
    end

    // +1 when the comparator agrees with the phase (high in A, low in B), else -1.
    assign acc_nxt = ((chop_state == 1'b0) == cmp_s_q) ? acc_q + ONE : acc_q - ONE;

    // Measurement sequencing; ena low aborts to IDLE without touching the result.
    always_comb begin
        st_d  = st_q;
        acc_d = acc_q;
        smp_d = smp_q;
        res_d = res_q;
        case (st_q)
            IDLE: if (start) st_d = ARM;
            ARM: begin
                if (half_start) begin
                    st_d  = RUN;
                    acc_d = '0;
                    smp_d = '0;
                end
            end
            RUN: begin
                if (sample_en) begin
                    acc_d = acc_nxt;
                    smp_d = smp_q + 7'd1;
                    if (smp_q == LAST_SMP) begin
                        st_d  = DONE;
                        res_d = acc_nxt;
                    end
                end
            end
            DONE:    st_d = IDLE;
            default: st_d = IDLE;
        endcase
        if (!ena) st_d = IDLE;
    end

    // FSM, accumulator and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= IDLE;
            acc_q <= '0;
            smp_q <= '0;
            res_q <= '0;
        end else begin
            st_q  <= st_d;
            acc_q <= acc_d;
            smp_q <= smp_d;
            res_q <= res_d;
        end
    end

    assign busy         = (st_q == ARM) || (st_q == RUN);
    assign result_valid = (st_q == DONE);
    assign result       = res_q;

endmodule

// File: tb/tb_chop_phase_demod.sv
module tb_chop_phase_demod;

    logic       clk = 1'b0;
    logic       rst_n, ena, start0, start1, cmp_in;
    logic [2:0] div_sel;
    logic [1:0] dead_sel;
    logic       phi1_0, phi2_0, cs0, busy0, rv0;
    logic       phi1_1, phi2_1, cs1, busy1, rv1;
    logic [7:0] res0, res1;

    int checks = 0;
    int errors = 0;
    int mode   = 0;   // 0: cmp=0, 1: cmp=1, 2: 1 in A / 0 in B, 3: 0 in A / 1 in B
    bit sel    = 1'b0;

    logic       busy_m, rv_m;
    logic [7:0] res_m;
    assign busy_m = sel ? busy1 : busy0;
    assign rv_m   = sel ? rv1   : rv0;
    assign res_m  = sel ? res1  : res0;

    chop_phase_demod #(.NPER(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .div_sel(div_sel), .dead_sel(dead_sel),
        .start(start0), .cmp_in(cmp_in), .phi1(phi1_0), .phi2(phi2_0), .chop_state(cs0),
        .busy(busy0), .result(res0), .result_valid(rv0)
    );

    chop_phase_demod #(.NPER(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .div_sel(div_sel), .dead_sel(dead_sel),
        .start(start1), .cmp_in(cmp_in), .phi1(phi1_1), .phi2(phi2_1), .chop_state(cs1),
        .busy(busy1), .result(res1), .result_valid(rv1)
    );

    always #5 clk = ~clk;

    // Comparator model: changes away from the sampling edge.
    always @(negedge clk) begin
        case (mode)
            0:       cmp_in = 1'b0;
            1:       cmp_in = 1'b1;
            2:       cmp_in = ~cs0;
            default: cmp_in = cs0;
        endcase
    end

    // The two chopper phases must never overlap.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            if (phi1_0 && phi2_0) begin
                errors++;
                $display("FAIL phase_overlap: phi1=%b phi2=%b required not both 1 at %0t", phi1_0, phi2_0, $time);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input bit v);
        if (sel) start1 = v;
        else     start0 = v;
    endtask

    // Align to the first cycle of half-period A (c=0).
    task automatic wait_a0;
        bit prev;
        bit found;
        found = 1'b0;
        prev  = cs0;
        for (int n = 0; n < 2000 && !found; n++) begin
            tick;
            if (prev && !cs0) found = 1'b1;
            prev = cs0;
        end
        chk("align_a0", 32'(found), 32'd1);
    endtask

    task automatic measure(input logic [7:0] exp, input int bound, input bit extra, input string nm);
        int lat;
        int strobes;
        bit bz_ok;
        bit bz_after;
        bz_ok    = 1'b1;
        bz_after = 1'b0;
        strobes  = 0;
        set_start(1'b1);
        tick;
        set_start(1'b0);
        chk({nm, "_busy_rise"}, 32'(busy_m), 32'd1);
        lat = 1;
        while (rv_m !== 1'b1 && lat <= bound + 4) begin
            if (busy_m !== 1'b1) bz_ok = 1'b0;
            set_start(extra && lat == 20);
            tick;
            lat++;
        end
        chk({nm, "_strobe"}, 32'(rv_m), 32'd1);
        chk({nm, "_latency_ok"}, 32'(lat <= bound), 32'd1);
        chk({nm, "_busy_done"}, 32'(busy_m), 32'd0);
        chk({nm, "_result"}, 32'(res_m), 32'(exp));
        chk({nm, "_busy_held"}, 32'(bz_ok), 32'd1);
        // a request in the DONE cycle must be dropped
        set_start(1'b1);
        tick;
        set_start(1'b0);
        for (int i = 0; i < 12; i++) begin
            if (rv_m) strobes++;
            if (busy_m) bz_after = 1'b1;
            tick;
        end
        chk({nm, "_single_strobe"}, 32'(strobes), 32'd0);
        chk({nm, "_start_in_done_ignored"}, 32'(bz_after), 32'd0);
        chk({nm, "_result_hold"}, 32'(res_m), 32'(exp));
    endtask

    typedef struct {
        logic [2:0] div;
        logic [1:0] dead;
        int         mode;
        bit         dut;
        bit         extra;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int strobes;
        int h;
        int nper;

        tbl[0] = '{3'd1, 2'd3, 2, 1'b0, 1'b0, 8'h20};
        tbl[1] = '{3'd1, 2'd3, 3, 1'b0, 1'b1, 8'hE0};
        tbl[2] = '{3'd1, 2'd3, 1, 1'b0, 1'b0, 8'h00};
        tbl[3] = '{3'd0, 2'd0, 2, 1'b0, 1'b0, 8'h20};
        tbl[4] = '{3'd2, 2'd1, 3, 1'b0, 1'b0, 8'hE0};
        tbl[5] = '{3'd0, 2'd0, 2, 1'b1, 1'b0, 8'h02};
        tbl[6] = '{3'd0, 2'd2, 3, 1'b1, 1'b0, 8'hFE};

        rst_n = 1'b0; ena = 1'b1; start0 = 1'b0; start1 = 1'b0;
        div_sel = 3'd0; dead_sel = 2'd0; mode = 0;

        // reset values
        repeat (3) tick;
        chk("rst_phi1", 32'(phi1_0), 32'd0);
        chk("rst_phi2", 32'(phi2_0), 32'd0);
        chk("rst_chop_state", 32'(cs0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_result", 32'(res0), 32'd0);
        chk("rst_result_valid", 32'(rv0), 32'd0);
        chk("rst_busy_n1", 32'(busy1), 32'd0);

        // H=4, D=1 phase pattern after release
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) tick;
            chk($sformatf("pat_phi1_%0d", i), 32'(phi1_0), 32'((i % 8) >= 1 && (i % 8) <= 3));
            chk($sformatf("pat_phi2_%0d", i), 32'(phi2_0), 32'((i % 8) >= 5));
            chk($sformatf("pat_cs_%0d", i),   32'(cs0),    32'((i % 8) >= 4));
        end

        // dead time clamp: H=4, dead_sel=3 -> D=3
        dead_sel = 2'd3;
        repeat (10) tick;
        wait_a0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick;
            chk($sformatf("clamp_phi1_%0d", i), 32'(phi1_0), 32'(i == 3));
            chk($sformatf("clamp_phi2_%0d", i), 32'(phi2_0), 32'(i == 7));
        end

        // div_sel changes mid-half only take effect at the next boundary
        wait_a0;
        for (int i = 1; i <= 24; i++) begin
            tick;
            if (i == 1)  div_sel = 3'd2;
            if (i == 10) div_sel = 3'd0;
            case (i)
                3:  chk("mid_cs_i3", 32'(cs0), 32'd0);
                4: begin
                    chk("mid_cs_i4", 32'(cs0), 32'd1);
                    chk("mid_phi2_i4", 32'(phi2_0), 32'd0);
                end
                7:  chk("mid_phi2_i7", 32'(phi2_0), 32'd0);
                8:  chk("mid_phi2_i8", 32'(phi2_0), 32'd1);
                19: chk("mid_cs_i19", 32'(cs0), 32'd1);
                20: chk("mid_cs_i20", 32'(cs0), 32'd0);
                23: chk("mid_cs_i23", 32'(cs0), 32'd0);
                24: chk("mid_cs_i24", 32'(cs0), 32'd1);
                default: ;
            endcase
        end

        // table of full measurements
        for (int r = 0; r < 7; r++) begin
            sel      = tbl[r].dut;
            div_sel  = tbl[r].div;
            dead_sel = tbl[r].dead;
            mode     = tbl[r].mode;
            repeat (40) tick;
            h    = 4 << tbl[r].div;
            nper = tbl[r].dut ? 1 : 16;
            measure(tbl[r].exp, 2 * h + 2 * nper * h + 2, tbl[r].extra, $sformatf("vec%0d", r));
        end

        // drop ena mid-RUN: abort, no strobe, result held
        sel = 1'b0; div_sel = 3'd1; dead_sel = 2'd3; mode = 2;
        repeat (40) tick;
        set_start(1'b1);
        tick;
        set_start(1'b0);
        repeat (60) tick;
        chk("ena_busy_before", 32'(busy0), 32'd1);
        ena = 1'b0;
        tick;
        chk("ena_busy", 32'(busy0), 32'd0);
        chk("ena_phi1", 32'(phi1_0), 32'd0);
        chk("ena_phi2", 32'(phi2_0), 32'd0);
        chk("ena_cs", 32'(cs0), 32'd0);
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            if (rv0 || phi1_0 || phi2_0) strobes++;
            tick;
        end
        chk("ena_quiet", 32'(strobes), 32'd0);
        chk("ena_result_hold", 32'(res0), 32'hE0);
        // start while disabled is dropped
        set_start(1'b1);
        tick;
        set_start(1'b0);
        ena = 1'b1;
        tick;
        chk("ena_start_ignored", 32'(busy0), 32'd0);
        measure(8'h20, 2 * 8 + 2 * 16 * 8 + 2, 1'b0, "reen");

        // asynchronous reset mid-measurement
        set_start(1'b1);
        tick;
        set_start(1'b0);
        repeat (30) tick;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy0), 32'd0);
        chk("arst_result", 32'(res0), 32'd0);
        chk("arst_valid", 32'(rv0), 32'd0);
        chk("arst_phi1", 32'(phi1_0), 32'd0);
        strobes = 0;
        for (int i = 0; i < 10; i++) begin
            if (rv0) strobes++;
            tick;
        end
        chk("arst_no_strobe", 32'(strobes), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
